// File: rtl/sv_reduce_accum.sv
// Multi-lane, multi-beat AND/OR/XOR/XNOR reduction engine with valid/ready streams and a one-entry output register.
// Optional saturating packet counter on pkt_count, enabled by defining REDUCE_ACCUM_STATS_EN.
module sv_reduce_accum #(
    parameter int LANES = 4,
    parameter int WIDTH = 9,
    parameter int OUT_W = 6,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [1:0]             in_op,
    input  logic                   in_signed,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data
`ifdef REDUCE_ACCUM_STATS_EN
    ,
    output logic [CNT_W-1:0]       pkt_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XNOR = 2'b11;

    state_t                   state_q, state_d;
    logic [LANES-1:0]         acc_q, acc_d;
    logic [1:0]               op_q, op_d;
    logic                     signed_q, signed_d;
    logic                     out_valid_q, out_valid_d;
    logic [LANES*OUT_W-1:0]   out_data_q, out_data_d;

    logic [LANES-1:0]         red_and, red_or, red_xor;
    logic [LANES-1:0]         lane_red, folded, res_bit;
    logic [LANES*OUT_W-1:0]   ext_data;
    logic                     accept;
    logic [1:0]               eff_op;
    logic                     eff_signed;

    // Op and sign come from the input on the first beat and from the latched copy afterwards.
    assign eff_op     = (state_q == IDLE) ? in_op : op_q;
    assign eff_signed = (state_q == IDLE) ? in_signed : signed_q;
    assign res_bit    = folded ^ {LANES{eff_op == OP_XNOR}};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign red_and[gi] = &in_data[gi*WIDTH +: WIDTH];
            assign red_or[gi]  = |in_data[gi*WIDTH +: WIDTH];
            assign red_xor[gi] = ^in_data[gi*WIDTH +: WIDTH];
            assign ext_data[gi*OUT_W +: OUT_W] = eff_signed ? {OUT_W{res_bit[gi]}}
                                                            : OUT_W'(res_bit[gi]);
        end
    endgenerate

    assign in_ready  = ~out_valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        case (eff_op)
            OP_AND:  lane_red = red_and;
            OP_OR:   lane_red = red_or;
            default: lane_red = red_xor;
        endcase

        // XNOR folds as XOR; the inversion is applied only to the emitted bit.
        if (state_q == IDLE) begin
            folded = lane_red;
        end else begin
            case (op_q)
                OP_AND:  folded = acc_q & lane_red;
                OP_OR:   folded = acc_q | lane_red;
                default: folded = acc_q ^ lane_red;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        signed_d    = signed_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;

        if (accept) begin
            acc_d = folded;
            if (state_q == IDLE) begin
                op_d     = in_op;
                signed_d = in_signed;
            end
            if (in_last) begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                out_data_d  = ext_data;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            signed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            signed_q    <= signed_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef REDUCE_ACCUM_STATS_EN
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (out_valid_q && out_ready && (pkt_count_q != {CNT_W{1'b1}})) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule
